// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
//   MDU_WIDTH   : default operand width
//   MDU_MULTU   : op encoding for unsigned multiply
//   MDU_DIVU    : op encoding for unsigned divide
//   mdu_state_e : controller states IDLE / RUN / DONE
package hilo_muldiv_unit_pkg;

  localparam int unsigned MDU_WIDTH = 32;

  localparam logic MDU_MULTU = 1'b0;
  localparam logic MDU_DIVU  = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/hilo_muldiv_unit_iter_step.sv
// mdu_iter_step: one combinational iteration of the multiply/divide loop.
//   op_i  : MDU_MULTU (shift-add) or MDU_DIVU (restoring divide)
//   acc_i : 2*WIDTH working accumulator
//             multu: {partial product high, remaining multiplier bits}
//             divu : {partial remainder, dividend/quotient bits}
//   b_i   : operand held constant for the whole op (addend / divisor)
//   acc_o : accumulator after this iteration
module mdu_iter_step
  import hilo_muldiv_unit_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
) (
  input  logic               op_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0]   mul_sum;  // upper half plus addend, carry kept
  logic [WIDTH:0]   rem_sh;   // shifted partial remainder (WIDTH+1 bits)
  logic             rem_geq;  // trial subtraction is non-negative
  logic [WIDTH-1:0] rem_sub;  // remainder after successful subtraction

  always_comb begin
    mul_sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, b_i} : '0);

    rem_sh  = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
    rem_geq = (rem_sh >= {1'b0, b_i});
    // When rem_sh >= b the difference is below b, so WIDTH bits are exact.
    rem_sub = rem_sh[WIDTH-1:0] - b_i;

    if (op_i == MDU_MULTU) begin
      // Carry lands in the top bit as the accumulator shifts right.
      acc_o = {mul_sum, acc_i[WIDTH-1:1]};
    end else if (rem_geq) begin
      acc_o = {rem_sub, acc_i[WIDTH-2:0], 1'b1};
    end else begin
      acc_o = {rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: iterative unsigned multiply/divide owning HI/LO.
//   clk, rst     : rising-edge clock, synchronous active-low reset
//   start, op    : launch an op (0 = multu, 1 = divu), sampled in IDLE/DONE
//   a, b         : rs / rt operands
//   we_hi, we_lo : mthi / mtlo write enables, wd is the write data
//   busy         : high while an op iterates; controller stalls
//   done         : one-cycle pulse when hi/lo hold a new result
//   hi, lo       : HI / LO registers
module hilo_muldiv_unit
  import hilo_muldiv_unit_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             we_hi,
  input  logic             we_lo,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  mdu_state_e         state_q;
  logic [CW-1:0]      cnt_q;
  logic               op_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               busy_q;
  logic               done_q;

  logic               last_iter;
  logic               div_zero;

  // Multiplication is commutative, so a is loaded as the shifted operand
  // and b is the addend; both ops then share the same load and unload.
  mdu_iter_step #(.WIDTH(WIDTH)) u_step (
    .op_i  (op_q),
    .acc_i (acc_q),
    .b_i   (b_q),
    .acc_o (acc_d)
  );

  assign last_iter = (cnt_q == CW'(WIDTH - 1));
  assign div_zero  = (op == MDU_DIVU) && (b == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= MDU_MULTU;
      b_q     <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          // mthi/mtlo first so a same-edge result write takes priority.
          if (we_hi) hi_q <= wd;
          if (we_lo) lo_q <= wd;
          if (start) begin
            if (div_zero) begin
              hi_q    <= a;
              lo_q    <= '1;
              state_q <= DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              op_q    <= op;
              b_q     <= b;
              acc_q   <= {{WIDTH{1'b0}}, a};
              cnt_q   <= '0;
              state_q <= RUN;
              busy_q  <= 1'b1;
            end
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CW'(1);
          if (last_iter) begin
            hi_q    <= acc_d[2*WIDTH-1:WIDTH];
            lo_q    <= acc_d[WIDTH-1:0];
            state_q <= DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Testbench for hilo_muldiv_unit: expected {hi,lo} results are pushed to a
// queue at launch and popped when done pulses.
module tb_hilo_muldiv_unit;
  import hilo_muldiv_unit_pkg::*;

  localparam int unsigned W      = 32;
  localparam int unsigned BUDGET = 3 * W;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         we_hi;
  logic         we_lo;
  logic [W-1:0] wd;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int unsigned    n_checks = 0;
  int unsigned    n_fail   = 0;
  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   cur_hi;
  logic [W-1:0]   cur_lo;

  always #5 clk = ~clk;

  hilo_muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .we_hi (we_hi),
    .we_lo (we_lo),
    .wd    (wd),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  function automatic logic [2*W-1:0] model(input logic o, input logic [W-1:0] x,
                                           input logic [W-1:0] y);
    logic [2*W-1:0] p;
    if (o == MDU_MULTU)  p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    else if (y == '0)    p = {x, {W{1'b1}}};
    else                 p = {x % y, x / y};
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    exp_q.push_back(model(o, x, y));
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    n_checks++;
    if ({busy, done, hi, lo} !== '0) begin
      $display("FAIL reset: busy=%b done=%b hi=%h lo=%h, expected all zero", busy, done, hi, lo);
      n_fail++;
    end
    cur_hi = '0;
    cur_lo = '0;
  endtask

  task automatic test_arith();
    logic           xo [9];
    logic [W-1:0]   xa [9];
    logic [W-1:0]   xb [9];
    logic [2*W-1:0] want;
    int unsigned    cyc;
    int unsigned    run_bad;
    xo[0] = MDU_MULTU; xa[0] = 32'd3;          xb[0] = 32'd5;
    xo[1] = MDU_MULTU; xa[1] = 32'hFFFF_FFFF;  xb[1] = 32'hFFFF_FFFF;
    xo[2] = MDU_MULTU; xa[2] = 32'h8000_0001;  xb[2] = 32'hFFFF_FFFF;
    xo[3] = MDU_MULTU; xa[3] = $urandom;       xb[3] = $urandom;
    xo[4] = MDU_DIVU;  xa[4] = 32'd100;        xb[4] = 32'd7;
    xo[5] = MDU_DIVU;  xa[5] = 32'd5;          xb[5] = 32'd9;
    xo[6] = MDU_DIVU;  xa[6] = 32'hFFFF_FFFF;  xb[6] = 32'd1;
    xo[7] = MDU_DIVU;  xa[7] = 32'hFFFF_FFFF;  xb[7] = 32'hFFFF_FFFF;
    xo[8] = MDU_DIVU;  xa[8] = $urandom;       xb[8] = $urandom_range(32'hFFFF, 1);
    for (int i = 0; i < 9; i++) begin
      launch(xo[i], xa[i], xb[i]);
      cyc     = 0;
      run_bad = 0;
      while (!done && cyc < BUDGET) begin
        if (busy !== 1'b1 || hi !== cur_hi || lo !== cur_lo) run_bad++;
        tick();
        cyc++;
      end
      n_checks++;
      if (cyc != W) begin
        $display("FAIL arith_latency[%0d]: done after %0d cycles, expected %0d", i, cyc, W);
        n_fail++;
      end
      n_checks++;
      if (run_bad != 0) begin
        $display("FAIL arith_run[%0d]: %0d RUN cycles with busy low or hi/lo moving, expected 0",
                 i, run_bad);
        n_fail++;
      end
      want = exp_q.pop_front();
      n_checks++;
      if ({hi, lo} !== want || busy !== 1'b0) begin
        $display("FAIL arith_result[%0d] op=%0d a=%h b=%h: hi=%h lo=%h busy=%b, expected hi=%h lo=%h busy=0",
                 i, xo[i], xa[i], xb[i], hi, lo, busy, want[2*W-1:W], want[W-1:0]);
        n_fail++;
      end
      cur_hi = want[2*W-1:W];
      cur_lo = want[W-1:0];
      tick();
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        $display("FAIL arith_done_pulse[%0d]: done=%b busy=%b after DONE, expected 0 0", i, done, busy);
        n_fail++;
      end
    end
  endtask

  task automatic test_div_zero();
    logic [2*W-1:0] want;
    we_hi = 1'b1;
    wd    = 32'hDEAD_BEEF;
    launch(MDU_DIVU, 32'h1234, '0);
    we_hi = 1'b0;
    want  = exp_q.pop_front();
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || {hi, lo} !== want) begin
      $display("FAIL div_zero: done=%b busy=%b hi=%h lo=%h, expected done=1 busy=0 hi=%h lo=%h",
               done, busy, hi, lo, want[2*W-1:W], want[W-1:0]);
      n_fail++;
    end
    cur_hi = want[2*W-1:W];
    cur_lo = want[W-1:0];
    tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL div_zero_after: done=%b busy=%b, expected 0 0", done, busy);
      n_fail++;
    end
  endtask

  task automatic test_mt_writes();
    logic [2*W-1:0] want;
    int unsigned    cyc;
    we_hi = 1'b1;
    wd    = 32'hA5A5_A5A5;
    tick();
    we_hi = 1'b0;
    n_checks++;
    if (hi !== 32'hA5A5_A5A5 || lo !== cur_lo) begin
      $display("FAIL mthi_idle: hi=%h lo=%h, expected hi=a5a5a5a5 lo=%h", hi, lo, cur_lo);
      n_fail++;
    end
    cur_hi = 32'hA5A5_A5A5;
    we_lo  = 1'b1;
    wd     = 32'h5A5A_0F0F;
    tick();
    we_lo  = 1'b0;
    n_checks++;
    if (lo !== 32'h5A5A_0F0F || hi !== cur_hi) begin
      $display("FAIL mtlo_idle: hi=%h lo=%h, expected hi=%h lo=5a5a0f0f", hi, lo, cur_hi);
      n_fail++;
    end
    cur_lo = 32'h5A5A_0F0F;
    // mtlo lands with the launch, then is overwritten at completion.
    we_lo = 1'b1;
    wd    = 32'h0000_CAFE;
    launch(MDU_MULTU, 32'd6, 32'd7);
    we_lo = 1'b0;
    n_checks++;
    if (lo !== 32'h0000_CAFE || hi !== cur_hi || busy !== 1'b1) begin
      $display("FAIL mtlo_with_start: hi=%h lo=%h busy=%b, expected hi=%h lo=0000cafe busy=1",
               hi, lo, busy, cur_hi);
      n_fail++;
    end
    cur_lo = 32'h0000_CAFE;
    we_lo  = 1'b1;
    wd     = 32'hFFFF_0000;
    tick();
    we_lo  = 1'b0;
    n_checks++;
    if (lo !== cur_lo) begin
      $display("FAIL mtlo_run: lo=%h, expected %h", lo, cur_lo);
      n_fail++;
    end
    cyc = 0;
    while (!done && cyc < BUDGET) begin
      tick();
      cyc++;
    end
    want = exp_q.pop_front();
    n_checks++;
    if (cyc != W - 1 || {hi, lo} !== want) begin
      $display("FAIL mt_then_result: cycles=%0d hi=%h lo=%h, expected cycles=%0d hi=%h lo=%h",
               cyc, hi, lo, W - 1, want[2*W-1:W], want[W-1:0]);
      n_fail++;
    end
    cur_hi = want[2*W-1:W];
    cur_lo = want[W-1:0];
    tick();
  endtask

  task automatic test_start_ignored();
    logic [2*W-1:0] want;
    int unsigned    cyc;
    launch(MDU_MULTU, 32'd3, 32'd5);
    repeat (9) tick();
    start = 1'b1;
    op    = MDU_DIVU;
    a     = 32'd7;
    b     = 32'd9;
    we_lo = 1'b1;
    wd    = 32'h0BAD_0BAD;
    tick();
    start = 1'b0;
    we_lo = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || lo !== cur_lo) begin
      $display("FAIL start_in_run: busy=%b lo=%h, expected busy=1 lo=%h", busy, lo, cur_lo);
      n_fail++;
    end
    cyc = 0;
    while (!done && cyc < BUDGET) begin
      tick();
      cyc++;
    end
    want = exp_q.pop_front();
    n_checks++;
    if (cyc != W - 10 || {hi, lo} !== want) begin
      $display("FAIL start_ignored_result: cycles=%0d hi=%h lo=%h, expected cycles=%0d hi=%h lo=%h",
               cyc, hi, lo, W - 10, want[2*W-1:W], want[W-1:0]);
      n_fail++;
    end
    cur_hi = want[2*W-1:W];
    cur_lo = want[W-1:0];
    tick();
  endtask

  task automatic test_reset_mid_run();
    int unsigned bad;
    launch(MDU_MULTU, $urandom | 32'h1, $urandom | 32'h1);
    repeat (19) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    void'(exp_q.pop_back());
    cur_hi = '0;
    cur_lo = '0;
    n_checks++;
    if ({busy, done, hi, lo} !== '0) begin
      $display("FAIL reset_mid_run: busy=%b done=%b hi=%h lo=%h, expected all zero", busy, done, hi, lo);
      n_fail++;
    end
    bad = 0;
    repeat (W + 5) begin
      if (done !== 1'b0 || busy !== 1'b0 || hi !== '0 || lo !== '0) bad++;
      tick();
    end
    n_checks++;
    if (bad != 0) begin
      $display("FAIL reset_abort: %0d cycles with activity after abort, expected 0", bad);
      n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    logic [2*W-1:0] want;
    int unsigned    cyc;
    launch(MDU_MULTU, 32'h0001_0003, 32'h0002_0005);
    cyc = 0;
    while (!done && cyc < BUDGET) begin
      tick();
      cyc++;
    end
    want = exp_q.pop_front();
    n_checks++;
    if (cyc != W || {hi, lo} !== want) begin
      $display("FAIL b2b_first: cycles=%0d hi=%h lo=%h, expected cycles=%0d hi=%h lo=%h",
               cyc, hi, lo, W, want[2*W-1:W], want[W-1:0]);
      n_fail++;
    end
    launch(MDU_DIVU, 32'd1000, 32'd33);
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      $display("FAIL b2b_relaunch: busy=%b done=%b, expected busy=1 done=0", busy, done);
      n_fail++;
    end
    cyc = 0;
    while (!done && cyc < BUDGET) begin
      tick();
      cyc++;
    end
    want = exp_q.pop_front();
    n_checks++;
    if (cyc != W || {hi, lo} !== want) begin
      $display("FAIL b2b_second: cycles=%0d hi=%h lo=%h, expected cycles=%0d hi=%h lo=%h",
               cyc, hi, lo, W, want[2*W-1:W], want[W-1:0]);
      n_fail++;
    end
    launch(MDU_DIVU, 32'd77, '0);
    want = exp_q.pop_front();
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || {hi, lo} !== want) begin
      $display("FAIL b2b_div_zero: done=%b busy=%b hi=%h lo=%h, expected done=1 busy=0 hi=%h lo=%h",
               done, busy, hi, lo, want[2*W-1:W], want[W-1:0]);
      n_fail++;
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL b2b_idle: done=%b busy=%b, expected 0 0", done, busy);
      n_fail++;
    end
  endtask

  initial begin
    rst    = 1'b0;
    start  = 1'b0;
    op     = MDU_MULTU;
    a      = '0;
    b      = '0;
    we_hi  = 1'b0;
    we_lo  = 1'b0;
    wd     = '0;
    cur_hi = '0;
    cur_lo = '0;
    test_reset();
    test_arith();
    test_div_zero();
    test_mt_writes();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
